// File: rtl/proc_pkg.sv
// Shared widths, MEM-stage FSM encoding and the MEM/WB bubble control value
// for the 16-bit five-stage pipeline.
package proc_pkg;
  localparam int DW = 16;
  localparam int RW = 3;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic regWrite;
    logic halt;
  } wb_ctrl_t;

  localparam wb_ctrl_t WB_BUBBLE = '{regWrite: 1'b0, halt: 1'b0};
endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: synchronous active-high clear, load on enable.
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst)       q_q <= '0;
    else if (en_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM and MEM/WB registers, handshaked data-memory port
// and upstream stall. Optional misalignment trap under MEM_ALIGN_CHECK_EN.
module mem_stage #(
  parameter int DW = proc_pkg::DW,
  parameter int RW = proc_pkg::RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_ALURes,
  input  logic [DW-1:0] ex_rt,
  input  logic [DW-1:0] ex_nextPC,
  input  logic          ex_memRead,
  input  logic          ex_memWrite,
  input  logic          ex_memToReg,
  input  logic          ex_regWrite,
  input  logic          ex_halt,
  input  logic [RW-1:0] ex_writeReg,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_stall,
  input  logic          mem_done,
  output logic [DW-1:0] exmem_ALURes,
  output logic [DW-1:0] exmem_nextPC,
  output logic          exmem_regWrite,
  output logic [RW-1:0] exmem_writeReg,
  output logic [DW-1:0] memwb_writeBack,
  output logic [DW-1:0] memwb_nextPC,
  output logic          memwb_regWrite,
  output logic [RW-1:0] memwb_writeReg,
  output logic          memwb_halt,
  output logic          stall,
  output logic          err
);
  import proc_pkg::*;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] alu;
    logic [DW-1:0] rt;
    logic [DW-1:0] npc;
    logic          rd;
    logic          wr;
    logic          m2r;
    logic          rw;
    logic          halt;
    logic [RW-1:0] wreg;
  } exmem_t;

  typedef struct packed {
    logic [DW-1:0] wb;
    logic [DW-1:0] npc;
    logic [RW-1:0] wreg;
    wb_ctrl_t      ctrl;
  } memwb_t;

  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;
  state_e state_d, state_q;
  logic   stall_w, rd_w, wr_w;
  logic   memop, misalign, issue;

  assign exmem_d = '{v: ex_valid, alu: ex_ALURes, rt: ex_rt, npc: ex_nextPC,
                     rd: ex_memRead, wr: ex_memWrite, m2r: ex_memToReg,
                     rw: ex_regWrite, halt: ex_halt, wreg: ex_writeReg};

  pipe_reg #(.W($bits(exmem_t))) u_exmem (
    .clk  (clk),
    .rst  (rst),
    .en_i (~stall_w),
    .d_i  (exmem_d),
    .q_o  (exmem_q)
  );

  assign memop = exmem_q.v & (exmem_q.rd | exmem_q.wr);

`ifdef MEM_ALIGN_CHECK_EN
  logic err_q;

  // An odd address is trapped before it reaches memory; it retires as a halting bubble.
  assign misalign = memop & exmem_q.alu[0] & (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (rst)           err_q <= 1'b0;
    else if (misalign) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign misalign = 1'b0;
  assign err      = 1'b0;
`endif

  assign issue = memop & ~misalign;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rd_w    = 1'b0;
    wr_w    = 1'b0;
    stall_w = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          rd_w = exmem_q.rd;
          wr_w = exmem_q.wr;
          if (mem_stall) begin
            stall_w = 1'b1;
          end else if (!mem_done) begin
            stall_w = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stall_w = ~mem_done;
        if (mem_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bubbles keep the data fields so forwarding sources don't glitch while stalled.
  always_comb begin
    memwb_d      = memwb_q;
    memwb_d.ctrl = WB_BUBBLE;
    if (!stall_w && exmem_q.v && !misalign) begin
      memwb_d.wb            = exmem_q.m2r ? mem_rdata : exmem_q.alu;
      memwb_d.npc           = exmem_q.npc;
      memwb_d.wreg          = exmem_q.wreg;
      memwb_d.ctrl.regWrite = exmem_q.rw;
      memwb_d.ctrl.halt     = exmem_q.halt;
    end
    if (misalign) memwb_d.ctrl.halt = 1'b1;
  end

  pipe_reg #(.W($bits(memwb_t))) u_memwb (
    .clk  (clk),
    .rst  (rst),
    .en_i (1'b1),
    .d_i  (memwb_d),
    .q_o  (memwb_q)
  );

  assign mem_addr        = exmem_q.alu;
  assign mem_wdata       = exmem_q.rt;
  assign mem_rd          = rd_w;
  assign mem_wr          = wr_w;
  assign stall           = stall_w;
  assign exmem_ALURes    = exmem_q.alu;
  assign exmem_nextPC    = exmem_q.npc;
  assign exmem_regWrite  = exmem_q.rw;
  assign exmem_writeReg  = exmem_q.wreg;
  assign memwb_writeBack = memwb_q.wb;
  assign memwb_nextPC    = memwb_q.npc;
  assign memwb_regWrite  = memwb_q.ctrl.regWrite;
  assign memwb_writeReg  = memwb_q.wreg;
  assign memwb_halt      = memwb_q.ctrl.halt;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, hit, miss, rejection, reset in
// WAIT, halt, and the misaligned-load behaviour for either build.
module tb_mem_stage;
  localparam int DW = 16;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid;
  logic [DW-1:0] ex_ALURes, ex_rt, ex_nextPC;
  logic          ex_memRead, ex_memWrite, ex_memToReg, ex_regWrite, ex_halt;
  logic [RW-1:0] ex_writeReg;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          mem_rd, mem_wr, mem_stall, mem_done;
  logic [DW-1:0] exmem_ALURes, exmem_nextPC;
  logic          exmem_regWrite;
  logic [RW-1:0] exmem_writeReg;
  logic [DW-1:0] memwb_writeBack, memwb_nextPC;
  logic          memwb_regWrite, memwb_halt;
  logic [RW-1:0] memwb_writeReg;
  logic          stall, err;

  int tests = 0;
  int fails = 0;
  int wr_cnt, rd_cnt, st_cnt;

  mem_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ALURes(ex_ALURes), .ex_rt(ex_rt),
    .ex_nextPC(ex_nextPC), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_memToReg(ex_memToReg), .ex_regWrite(ex_regWrite), .ex_halt(ex_halt),
    .ex_writeReg(ex_writeReg), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .mem_done(mem_done), .exmem_ALURes(exmem_ALURes), .exmem_nextPC(exmem_nextPC),
    .exmem_regWrite(exmem_regWrite), .exmem_writeReg(exmem_writeReg),
    .memwb_writeBack(memwb_writeBack), .memwb_nextPC(memwb_nextPC),
    .memwb_regWrite(memwb_regWrite), .memwb_writeReg(memwb_writeReg),
    .memwb_halt(memwb_halt), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ex(input logic [DW-1:0] alu, input logic [DW-1:0] rt,
                          input logic [DW-1:0] npc, input logic rd, input logic wr,
                          input logic m2r, input logic rw, input logic hlt,
                          input logic [RW-1:0] wreg);
    ex_valid = 1'b1; ex_ALURes = alu; ex_rt = rt; ex_nextPC = npc;
    ex_memRead = rd; ex_memWrite = wr; ex_memToReg = m2r; ex_regWrite = rw;
    ex_halt = hlt; ex_writeReg = wreg;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0; ex_memRead = 1'b0; ex_memWrite = 1'b0; ex_memToReg = 1'b0;
    ex_regWrite = 1'b0; ex_halt = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle_ex();
    ex_ALURes = '0; ex_rt = '0; ex_nextPC = '0; ex_writeReg = '0;
    mem_rdata = '0; mem_stall = 1'b0; mem_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset_stall", stall, 0);
    chk("reset_mem_rd", mem_rd, 0);
    chk("reset_wb", memwb_writeBack, 0);
    chk("reset_err", err, 0);

    // ADD, no memop
    drive_ex(16'h0042, 16'h0000, 16'h0100, 0, 0, 0, 1, 0, 3'd3);
    tick(); idle_ex(); #1;
    chk("add_exmem_alu", exmem_ALURes, 16'h0042);
    chk("add_exmem_rw", exmem_regWrite, 1);
    chk("add_stall", stall, 0);
    chk("add_no_req", {mem_rd, mem_wr}, 0);
    tick();
    chk("add_wb", memwb_writeBack, 16'h0042);
    chk("add_wb_rw", memwb_regWrite, 1);
    chk("add_wb_reg", memwb_writeReg, 3);
    chk("add_wb_npc", memwb_nextPC, 16'h0100);

    // Load hit
    drive_ex(16'h0010, 16'h0000, 16'h0102, 1, 0, 1, 1, 0, 3'd5);
    tick(); idle_ex();
    mem_done = 1'b1; mem_rdata = 16'hBEEF; #1;
    chk("hit_rd", mem_rd, 1);
    chk("hit_addr", mem_addr, 16'h0010);
    chk("hit_stall", stall, 0);
    tick(); mem_done = 1'b0; #1;
    chk("hit_wb", memwb_writeBack, 16'hBEEF);
    chk("hit_wb_rw", memwb_regWrite, 1);
    chk("hit_wb_reg", memwb_writeReg, 5);
    chk("hit_rd_after", mem_rd, 0);

    // Store, done three cycles after acceptance
    drive_ex(16'h0020, 16'h1234, 16'h0104, 0, 1, 0, 0, 0, 3'd0);
    tick(); idle_ex();
    wr_cnt = 0; st_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      mem_done = (c == 3); #1;
      if (c == 0) chk("st_wdata", mem_wdata, 16'h1234);
      wr_cnt += int'(mem_wr); st_cnt += int'(stall);
      tick();
      if (c < 3) begin
        chk("st_bubble_rw", memwb_regWrite, 0);
        chk("st_bubble_hold", memwb_writeBack, 16'hBEEF);
      end
    end
    mem_done = 1'b0;
    chk("st_wr_cycles", wr_cnt, 1);
    chk("st_stall_cycles", st_cnt, 3);
    chk("st_retire_wb", memwb_writeBack, 16'h0020);

    // Two rejected cycles then a hit
    drive_ex(16'h0030, 16'h0000, 16'h0106, 1, 0, 1, 1, 0, 3'd2);
    tick(); idle_ex();
    rd_cnt = 0; st_cnt = 0; mem_rdata = 16'h5A5A;
    for (int c = 0; c < 3; c++) begin
      mem_stall = (c < 2); mem_done = (c == 2); #1;
      rd_cnt += int'(mem_rd); st_cnt += int'(stall);
      tick();
    end
    mem_stall = 1'b0; mem_done = 1'b0;
    chk("rej_rd_cycles", rd_cnt, 3);
    chk("rej_stall_cycles", st_cnt, 2);
    chk("rej_wb", memwb_writeBack, 16'h5A5A);
    chk("rej_wb_rw", memwb_regWrite, 1);

    // Reset while waiting
    drive_ex(16'h0040, 16'h0000, 16'h0108, 1, 0, 1, 1, 0, 3'd4);
    tick(); idle_ex(); #1;
    chk("rw_accept_stall", stall, 1);
    tick();
    chk("rw_wait_stall", stall, 1);
    chk("rw_wait_no_rd", mem_rd, 0);
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("rw_stall", stall, 0);
    chk("rw_req", {mem_rd, mem_wr}, 0);
    chk("rw_addr", mem_addr, 0);
    chk("rw_exmem", exmem_ALURes, 0);
    chk("rw_wb", memwb_writeBack, 0);
    chk("rw_npc", memwb_nextPC, 0);

    // Halt passes through; stray mem_done in IDLE ignored
    drive_ex(16'h0000, 16'h0000, 16'h0200, 0, 0, 0, 0, 1, 3'd0);
    mem_done = 1'b1;
    tick(); idle_ex(); #1;
    chk("stray_done_stall", stall, 0);
    chk("stray_done_rd", mem_rd, 0);
    tick(); mem_done = 1'b0;
    chk("halt_wb", memwb_halt, 1);
    chk("halt_npc", memwb_nextPC, 16'h0200);

    // Misaligned load
    drive_ex(16'h0011, 16'h0000, 16'h0300, 1, 0, 1, 1, 0, 3'd6);
    tick(); idle_ex(); #1;
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_no_rd", mem_rd, 0);
    chk("mis_stall", stall, 0);
    tick();
    chk("mis_halt", memwb_halt, 1);
    chk("mis_rw", memwb_regWrite, 0);
    chk("mis_err", err, 1);
    tick(); tick();
    chk("mis_err_sticky", err, 1);
    rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("mis_err_clr", err, 0);
`else
    chk("mis_rd", mem_rd, 1);
    chk("mis_addr", mem_addr, 16'h0011);
    chk("mis_err", err, 0);
    mem_done = 1'b1; mem_rdata = 16'hC0DE;
    tick(); mem_done = 1'b0;
    chk("mis_wb", memwb_writeBack, 16'hC0DE);
    chk("mis_halt", memwb_halt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
